// File: rtl/multi_clock_if.sv
// Control and display signals of the multi_clock timekeeper, bundled for
// connection between a controller/bench (master) and the clock (slave).
interface multi_clock_if;
    logic       en;
    logic       adj_hour;
    logic       adj_minute;
    logic       mode_12h;
    logic       alarm_we;
    logic [4:0] alarm_hour_in;
    logic [5:0] alarm_min_in;
    logic       alarm_on;
    logic       alarm_ack;
    logic [7:0] hour;
    logic [7:0] min;
    logic [7:0] sec;
    logic       pm;
    logic       tweet;
    logic       alarm;

    modport master (
        output en, adj_hour, adj_minute, mode_12h, alarm_we, alarm_hour_in,
               alarm_min_in, alarm_on, alarm_ack,
        input  hour, min, sec, pm, tweet, alarm
    );

    modport slave (
        input  en, adj_hour, adj_minute, mode_12h, alarm_we, alarm_hour_in,
               alarm_min_in, alarm_on, alarm_ack,
        output hour, min, sec, pm, tweet, alarm
    );
endinterface

// File: rtl/multi_clock.sv
// 24 h binary timekeeper with tick prescaler, edge-detected set buttons,
// 12/24 h BCD display, programmable alarm with acknowledge and hourly chime.
module multi_clock #(
    parameter int unsigned DIV       = 1,
    parameter int unsigned CHIME_LEN = 3,
    parameter int unsigned ALARM_LEN = 30
) (
    input  logic         clk,
    input  logic         rst,
    multi_clock_if.slave bus
);
    localparam logic [15:0] PRESC_MAX  = 16'(DIV - 1);
    localparam logic [7:0]  CHIME_INIT = 8'(CHIME_LEN);
    localparam logic [7:0]  ALARM_INIT = 8'(ALARM_LEN);

    logic [15:0] presc_q, presc_d;
    logic [5:0]  sec_q, sec_d;
    logic [5:0]  min_q, min_d;
    logic [4:0]  hour_q, hour_d;
    logic [4:0]  alarm_hour_q, alarm_hour_d;
    logic [5:0]  alarm_min_q, alarm_min_d;
    logic        adj_hour_q, adj_hour_d;
    logic        adj_minute_q, adj_minute_d;
    logic [7:0]  chime_cnt_q, chime_cnt_d;
    logic [7:0]  alarm_cnt_q, alarm_cnt_d;

    logic        tick, hour_rise, min_rise, sec_wrap, min_wrap;
    logic        chime_start, alarm_trig;
    logic [4:0]  hour_inc, disp_hour;
    logic [5:0]  min_inc;

    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [5:0] tens, ones;
        tens = v / 6'd10;
        ones = v % 6'd10;
        return {tens[3:0], ones[3:0]};
    endfunction

    // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latch).
    always_comb begin
        hour_rise    = bus.adj_hour & ~adj_hour_q;
        min_rise     = bus.adj_minute & ~adj_minute_q;
        adj_hour_d   = bus.adj_hour;
        adj_minute_d = bus.adj_minute;

        tick    = bus.en && (presc_q == PRESC_MAX);
        presc_d = presc_q;
        if (bus.en) presc_d = tick ? 16'd0 : presc_q + 16'd1;

        sec_wrap = (sec_q == 6'd59);
        min_wrap = (min_q == 6'd59);
        hour_inc = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
        min_inc  = min_wrap ? 6'd0 : min_q + 6'd1;

        sec_d  = sec_q;
        min_d  = min_q;
        hour_d = hour_q;
        if (tick) begin
            sec_d = sec_wrap ? 6'd0 : sec_q + 6'd1;
            if (sec_wrap) begin
                min_d = min_inc;
                if (min_wrap) hour_d = hour_inc;
            end
        end
        // A button press replaces any carry arriving in the same field.
        if (min_rise)  min_d  = min_inc;
        if (hour_rise) hour_d = hour_inc;

        chime_start = tick && sec_wrap && min_wrap && !min_rise;
        alarm_trig  = tick && sec_wrap && !min_rise && !hour_rise && bus.alarm_on &&
                      (hour_d == alarm_hour_q) && (min_d == alarm_min_q);

        chime_cnt_d = chime_cnt_q;
        if (chime_start)                       chime_cnt_d = CHIME_INIT;
        else if (tick && chime_cnt_q != 8'd0)  chime_cnt_d = chime_cnt_q - 8'd1;

        alarm_cnt_d = alarm_cnt_q;
        if (alarm_trig)                          alarm_cnt_d = ALARM_INIT;
        else if (bus.alarm_ack || !bus.alarm_on) alarm_cnt_d = 8'd0;
        else if (tick && alarm_cnt_q != 8'd0)    alarm_cnt_d = alarm_cnt_q - 8'd1;

        alarm_hour_d = alarm_hour_q;
        alarm_min_d  = alarm_min_q;
        if (bus.alarm_we && bus.alarm_hour_in <= 5'd23 && bus.alarm_min_in <= 6'd59) begin
            alarm_hour_d = bus.alarm_hour_in;
            alarm_min_d  = bus.alarm_min_in;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q      <= '0;
            sec_q        <= '0;
            min_q        <= '0;
            hour_q       <= '0;
            alarm_hour_q <= '0;
            alarm_min_q  <= '0;
            adj_hour_q   <= 1'b0;
            adj_minute_q <= 1'b0;
            chime_cnt_q  <= '0;
            alarm_cnt_q  <= '0;
        end else begin
            presc_q      <= presc_d;
            sec_q        <= sec_d;
            min_q        <= min_d;
            hour_q       <= hour_d;
            alarm_hour_q <= alarm_hour_d;
            alarm_min_q  <= alarm_min_d;
            adj_hour_q   <= adj_hour_d;
            adj_minute_q <= adj_minute_d;
            chime_cnt_q  <= chime_cnt_d;
            alarm_cnt_q  <= alarm_cnt_d;
        end
    end

    always_comb begin
        disp_hour = hour_q;
        if (bus.mode_12h) begin
            if (hour_q == 5'd0)       disp_hour = 5'd12;
            else if (hour_q > 5'd12)  disp_hour = hour_q - 5'd12;
        end
        bus.hour  = to_bcd({1'b0, disp_hour});
        bus.min   = to_bcd(min_q);
        bus.sec   = to_bcd(sec_q);
        bus.pm    = (hour_q >= 5'd12);
        bus.tweet = (chime_cnt_q != 8'd0);
        bus.alarm = (alarm_cnt_q != 8'd0);
    end
endmodule

// File: tb/tb_multi_clock.sv
// Self-checking bench for multi_clock: directed scenarios plus a randomized run,
// all checked against a seconds-of-day reference model.
module tb_multi_clock;
    localparam int CHIME_LEN = 3;
    localparam int ALARM_LEN = 30;

    logic clk = 1'b0;
    logic rst, rst4;
    int   n_vec = 0;
    int   n_err = 0;

    multi_clock_if bus ();
    multi_clock_if bus4 ();

    multi_clock #(.DIV(1), .CHIME_LEN(CHIME_LEN), .ALARM_LEN(ALARM_LEN)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    multi_clock #(.DIV(4), .CHIME_LEN(CHIME_LEN), .ALARM_LEN(ALARM_LEN)) dut4 (
        .clk(clk), .rst(rst4), .bus(bus4)
    );

    always #5 clk = ~clk;

    // Reference model of the DIV=1 instance: time kept as seconds of the day.
    int tod, chime_left, alarm_left, al_h, al_m;
    bit prev_ah, prev_am;

    function automatic logic [7:0] bcd(input int v);
        return 8'((v / 10) * 16 + v % 10);
    endfunction

    function automatic logic [7:0] exp_hour();
        int h;
        h = tod / 3600;
        if (bus.mode_12h) h = (h == 0) ? 12 : ((h > 12) ? h - 12 : h);
        return bcd(h);
    endfunction

    function automatic logic [26:0] exp_all();
        return {exp_hour(), bcd((tod / 60) % 60), bcd(tod % 60), tod >= 12 * 3600,
                chime_left > 0, alarm_left > 0};
    endfunction

    task automatic model_step();
        bit ah_r, am_r, tk, chs, trig;
        int oh, om, nt, nh, nm, ns;
        if (rst) begin
            tod = 0; chime_left = 0; alarm_left = 0; al_h = 0; al_m = 0;
            prev_ah = 0; prev_am = 0;
            return;
        end
        oh   = tod / 3600;
        om   = (tod / 60) % 60;
        ah_r = bus.adj_hour && !prev_ah;
        am_r = bus.adj_minute && !prev_am;
        tk   = bus.en;
        nt   = tk ? (tod + 1) % 86400 : tod;
        nh   = nt / 3600;
        nm   = (nt / 60) % 60;
        ns   = nt % 60;
        if (am_r) nm = (om + 1) % 60;
        if (ah_r) nh = (oh + 1) % 24;
        chs  = tk && (nt % 3600 == 0) && !am_r;
        trig = tk && ns == 0 && nh == al_h && nm == al_m && bus.alarm_on && !am_r && !ah_r;
        if (chs) chime_left = CHIME_LEN;
        else if (tk && chime_left > 0) chime_left--;
        if (trig) alarm_left = ALARM_LEN;
        else if (bus.alarm_ack || !bus.alarm_on) alarm_left = 0;
        else if (tk && alarm_left > 0) alarm_left--;
        if (bus.alarm_we && bus.alarm_hour_in <= 23 && bus.alarm_min_in <= 59) begin
            al_h = bus.alarm_hour_in;
            al_m = bus.alarm_min_in;
        end
        tod     = nh * 3600 + nm * 60 + ns;
        prev_ah = bus.adj_hour;
        prev_am = bus.adj_minute;
    endtask

    task automatic do_cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick1();
        bus.en = 1'b1;
        do_cycle();
        bus.en = 1'b0;
    endtask

    // Reaches h:m:s with ticks (seconds), then minute and hour button presses.
    task automatic set_time(input int h, input int m, input int s);
        bus.en = 1'b1;
        while (tod % 60 != s) do_cycle();
        bus.en = 1'b0;
        while ((tod / 60) % 60 != m) begin
            bus.adj_minute = 1'b1; do_cycle();
            bus.adj_minute = 1'b0; do_cycle();
        end
        while (tod / 3600 != h) begin
            bus.adj_hour = 1'b1; do_cycle();
            bus.adj_hour = 1'b0; do_cycle();
        end
        n_vec++;
        if ({bus.hour, bus.min, bus.sec} !== {exp_hour(), bcd(m), bcd(s)}) begin
            n_err++;
            $display("FAIL set_time: got %h want %h", {bus.hour, bus.min, bus.sec},
                     {exp_hour(), bcd(m), bcd(s)});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rst4 = 1'b1;
        do_cycle(); do_cycle();
        rst = 1'b0; rst4 = 1'b0;
        n_vec++;
        if ({bus.hour, bus.min, bus.sec, bus.pm, bus.tweet, bus.alarm} !== 27'd0) begin
            n_err++;
            $display("FAIL reset_24h: got %h want %h",
                     {bus.hour, bus.min, bus.sec, bus.pm, bus.tweet, bus.alarm}, 27'd0);
        end
        bus.mode_12h = 1'b1;
        #1;
        n_vec++;
        if (bus.hour !== 8'h12) begin
            n_err++; $display("FAIL reset_12h_hour: got %h want 12", bus.hour);
        end
        bus.mode_12h = 1'b0;
        #1;
        n_vec++;
        if (bus4.sec !== 8'h00) begin
            n_err++; $display("FAIL reset_div4_sec: got %h want 00", bus4.sec);
        end
    endtask

    task automatic test_rollover();
        logic e;
        set_time(23, 59, 58);
        tick1();
        n_vec++;
        if ({bus.hour, bus.min, bus.sec, bus.pm, bus.tweet} !== {24'h235959, 2'b10}) begin
            n_err++;
            $display("FAIL rollover_2359: got %h want %h",
                     {bus.hour, bus.min, bus.sec, bus.pm, bus.tweet}, {24'h235959, 2'b10});
        end
        tick1();
        n_vec++;
        if ({bus.hour, bus.min, bus.sec, bus.pm, bus.tweet} !== {24'h000000, 2'b01}) begin
            n_err++;
            $display("FAIL rollover_0000: got %h want %h",
                     {bus.hour, bus.min, bus.sec, bus.pm, bus.tweet}, {24'h000000, 2'b01});
        end
        for (int k = 1; k <= 3; k++) begin
            do_cycle();
            n_vec++;
            if (bus.tweet !== 1'b1) begin
                n_err++; $display("FAIL chime_idle_%0d: got %b want 1", k, bus.tweet);
            end
            tick1();
            e = (k < 3);
            n_vec++;
            if (bus.tweet !== e) begin
                n_err++; $display("FAIL chime_tick_%0d: got %b want %b", k, bus.tweet, e);
            end
        end
    endtask

    task automatic test_prescaler();
        int gap;
        rst4 = 1'b1; do_cycle(); rst4 = 1'b0;
        for (int p = 1; p <= 8; p++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) do_cycle();
            n_vec++;
            if (bus4.sec !== bcd((p - 1) / 4)) begin
                n_err++; $display("FAIL presc_idle_%0d: got %h want %h", p, bus4.sec, bcd((p - 1) / 4));
            end
            bus4.en = 1'b1; do_cycle(); bus4.en = 1'b0;
            n_vec++;
            if (bus4.sec !== bcd(p / 4)) begin
                n_err++; $display("FAIL presc_pulse_%0d: got %h want %h", p, bus4.sec, bcd(p / 4));
            end
        end
        n_vec++;
        if (bus4.sec !== 8'h02) begin
            n_err++; $display("FAIL presc_final: got %h want 02", bus4.sec);
        end
    endtask

    task automatic test_adjust();
        set_time(0, 59, 30);
        bus.adj_minute = 1'b1;
        for (int k = 0; k < 10; k++) begin
            do_cycle();
            n_vec++;
            if ({bus.hour, bus.min, bus.sec, bus.tweet} !== {24'h000030, 1'b0}) begin
                n_err++;
                $display("FAIL adj_min_hold_%0d: got %h want %h", k,
                         {bus.hour, bus.min, bus.sec, bus.tweet}, {24'h000030, 1'b0});
            end
        end
        bus.adj_minute = 1'b0;
        do_cycle();
        set_time(0, 59, 59);
        bus.adj_hour = 1'b1;
        tick1();
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if ({bus.hour, bus.min, bus.sec} !== 24'h010000) begin
                n_err++;
                $display("FAIL adj_hour_carry_%0d: got %h want 010000", k, {bus.hour, bus.min, bus.sec});
            end
            do_cycle();
        end
        bus.adj_hour = 1'b0;
        do_cycle();
    endtask

    task automatic test_12h();
        int hrs [3] = '{0, 12, 13};
        logic [8:0] want [3] = '{{8'h12, 1'b0}, {8'h12, 1'b1}, {8'h01, 1'b1}};
        bus.mode_12h = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_time(hrs[i], (tod / 60) % 60, tod % 60);
            n_vec++;
            if ({bus.hour, bus.pm} !== want[i]) begin
                n_err++; $display("FAIL mode12_h%0d: got %h want %h", hrs[i], {bus.hour, bus.pm}, want[i]);
            end
        end
        bus.mode_12h = 1'b0;
        #1;
        n_vec++;
        if (bus.hour !== 8'h13) begin
            n_err++; $display("FAIL mode24_h13: got %h want 13", bus.hour);
        end
    endtask

    task automatic write_alarm(input int h, input int m);
        bus.alarm_we = 1'b1;
        bus.alarm_hour_in = 5'(h);
        bus.alarm_min_in = 6'(m);
        do_cycle();
        bus.alarm_we = 1'b0;
    endtask

    task automatic test_alarm();
        logic e;
        bus.alarm_on = 1'b0;
        write_alarm(7, 30);
        set_time(7, 29, 59);
        bus.alarm_on = 1'b1;
        do_cycle();
        n_vec++;
        if (bus.alarm !== 1'b0) begin
            n_err++; $display("FAIL alarm_early: got %b want 0", bus.alarm);
        end
        tick1();
        n_vec++;
        if ({bus.hour, bus.min, bus.sec, bus.alarm} !== {24'h073000, 1'b1}) begin
            n_err++;
            $display("FAIL alarm_fire: got %h want %h", {bus.hour, bus.min, bus.sec, bus.alarm}, {24'h073000, 1'b1});
        end
        for (int k = 1; k <= 5; k++) begin
            bus.alarm_ack = (k == 5);
            tick1();
            e = (k < 5);
            n_vec++;
            if (bus.alarm !== e) begin
                n_err++; $display("FAIL alarm_ack_%0d: got %b want %b", k, bus.alarm, e);
            end
        end
        bus.alarm_ack = 1'b0;
        bus.alarm_on = 1'b0;
        set_time(7, 29, 59);
        bus.alarm_on = 1'b1;
        tick1();
        for (int k = 1; k <= ALARM_LEN; k++) begin
            tick1();
            e = (k < ALARM_LEN);
            n_vec++;
            if (bus.alarm !== e) begin
                n_err++; $display("FAIL alarm_len_%0d: got %b want %b", k, bus.alarm, e);
            end
        end
        write_alarm(24, 15);
        write_alarm(9, 60);
        bus.alarm_on = 1'b0;
        set_time(7, 29, 59);
        bus.alarm_on = 1'b1;
        tick1();
        n_vec++;
        if (bus.alarm !== 1'b1) begin
            n_err++; $display("FAIL alarm_bad_write: got %b want 1", bus.alarm);
        end
    endtask

    task automatic test_reset_mid();
        bus.alarm_on = 1'b0;
        write_alarm(8, 0);
        set_time(7, 59, 59);
        bus.alarm_on = 1'b1;
        tick1();
        n_vec++;
        if ({bus.hour, bus.min, bus.sec, bus.tweet, bus.alarm} !== {24'h080000, 2'b11}) begin
            n_err++;
            $display("FAIL mid_both_on: got %h want %h",
                     {bus.hour, bus.min, bus.sec, bus.tweet, bus.alarm}, {24'h080000, 2'b11});
        end
        rst = 1'b1; do_cycle(); rst = 1'b0;
        n_vec++;
        if ({bus.hour, bus.min, bus.sec, bus.tweet, bus.alarm} !== 26'd0) begin
            n_err++;
            $display("FAIL mid_reset: got %h want %h", {bus.hour, bus.min, bus.sec, bus.tweet, bus.alarm}, 26'd0);
        end
        bus.alarm_on = 1'b0;
        set_time(23, 59, 59);
        bus.alarm_on = 1'b1;
        tick1();
        n_vec++;
        if ({bus.hour, bus.min, bus.sec, bus.tweet, bus.alarm} !== {24'h000000, 2'b11}) begin
            n_err++;
            $display("FAIL mid_alarm_regs_cleared: got %h want %h",
                     {bus.hour, bus.min, bus.sec, bus.tweet, bus.alarm}, {24'h000000, 2'b11});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2500; i++) begin
            bus.en         = 1'($urandom_range(0, 1));
            bus.adj_hour   = ($urandom_range(0, 15) == 0);
            bus.adj_minute = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 31) == 0) bus.mode_12h = ~bus.mode_12h;
            bus.alarm_on   = ($urandom_range(0, 15) != 0);
            bus.alarm_ack  = ($urandom_range(0, 63) == 0);
            bus.alarm_we   = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 1) == 0) begin
                bus.alarm_hour_in = 5'(tod / 3600);
                bus.alarm_min_in  = 6'(((tod / 60) % 60 + 1) % 60);
            end else begin
                bus.alarm_hour_in = 5'($urandom_range(0, 31));
                bus.alarm_min_in  = 6'($urandom_range(0, 63));
            end
            rst = ($urandom_range(0, 999) == 0);
            do_cycle();
            n_vec++;
            if ({bus.hour, bus.min, bus.sec, bus.pm, bus.tweet, bus.alarm} !== exp_all()) begin
                n_err++;
                $display("FAIL random_%0d: got %h want %h", i,
                         {bus.hour, bus.min, bus.sec, bus.pm, bus.tweet, bus.alarm}, exp_all());
            end
        end
        rst = 1'b0;
        {bus.en, bus.adj_hour, bus.adj_minute, bus.alarm_we, bus.alarm_on, bus.alarm_ack} = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rst4 = 1'b1;
        {bus.en, bus.adj_hour, bus.adj_minute, bus.mode_12h, bus.alarm_we, bus.alarm_on, bus.alarm_ack} = '0;
        bus.alarm_hour_in = '0; bus.alarm_min_in = '0;
        {bus4.en, bus4.adj_hour, bus4.adj_minute, bus4.mode_12h, bus4.alarm_we, bus4.alarm_on, bus4.alarm_ack} = '0;
        bus4.alarm_hour_in = '0; bus4.alarm_min_in = '0;
        test_reset();
        test_rollover();
        test_prescaler();
        test_adjust();
        test_12h();
        test_alarm();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/multi_clock.md
Name: multi_clock

Overview:
- Parametrised successor to the basic 24 h digital clock.
- Keeps time as HH:MM:SS in binary registers. Adds a prescaler on the tick enable, a 12/24 h display mode, edge-detected set buttons, a programmable alarm with acknowledge, and a timed hourly chime.
- Outputs are BCD for direct connection to the seven-segment display driver.

Parameters:
- DIV, 1: number of en pulses per second tick (1..65535).
- CHIME_LEN, 3: chime duration in seconds (1..255).
- ALARM_LEN, 30: maximum alarm duration in seconds (1..255).

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- en, input, 1: count enable pulse, one clk wide.
- adj_hour, input, 1: hour set button, level. Each rising edge means +1 hour.
- adj_minute, input, 1: minute set button, level. Each rising edge means +1 minute.
- mode_12h, input, 1: 1 selects 12 h display, 0 selects 24 h display.
- alarm_we, input, 1: load alarm time from alarm_hour_in and alarm_min_in.
- alarm_hour_in, input, 5: alarm hour, binary, 0..23.
- alarm_min_in, input, 6: alarm minute, binary, 0..59.
- alarm_on, input, 1: alarm armed, level.
- alarm_ack, input, 1: silence the alarm.
- hour, output, 8: display hour, BCD (two nibbles).
- min, output, 8: minute, BCD.
- sec, output, 8: second, BCD.
- pm, output, 1: 1 when internal hour is 12..23.
- tweet, output, 1: hourly chime.
- alarm, output, 1: alarm active.

Behaviour:
- Clock and reset: the only clock is clk. rst is synchronous and active-high.
- Reset values:
  - Time is 00:00:00 and the prescaler is 0.
  - Alarm registers are 00:00.
  - Edge-detect registers are 0.
  - Outputs after reset: hour=8'h00 (mode_12h=0) or 8'h12 (mode_12h=1), min=8'h00, sec=8'h00, pm=0, tweet=0, alarm=0.
- Prescaler:
  - The prescaler increments on each cycle with en=1.
  - tick = en && (prescaler == DIV-1). On tick the prescaler returns to 0.
  - With DIV=1, tick equals en.
- Counting on tick:
  - sec increments modulo 60.
  - At sec=59, the minute carry advances min modulo 60.
  - At min=59 with sec=59, the hour carry advances hour modulo 24 (23:59:59 becomes 00:00:00).
- Adjust:
  - adj_hour and adj_minute are registered once. A rise is input=1 while the previous sample was 0.
  - A rise of adj_minute sets min to min+1 modulo 60. It does not carry into hour and does not change sec.
  - A rise of adj_hour sets hour to hour+1 modulo 24.
  - If an adjust rise and a tick carry hit the same field in the same cycle, the adjust wins and the carry into that field is discarded. sec still advances.
  - Adjusts never trigger tweet or alarm.
- Display:
  - The hour/min/sec outputs are a combinational BCD decode of the registers, valid in the same cycle as the register update.
  - 12 h mapping: hour 0 displays 12, hours 1..12 display unchanged, hours 13..23 display hour-12.
  - pm is independent of mode.
- Alarm load:
  - When alarm_we=1, the alarm registers load on the next edge.
  - If alarm_hour_in>23 or alarm_min_in>59, the write is ignored entirely.
- Chime:
  - A tick whose result is MM:SS = 00:00 starts the chime. This includes the 23:59:59 rollover.
  - tweet goes high on the cycle after that edge and stays high for exactly CHIME_LEN ticks, counted by a down-counter decremented on tick.
  - A new hour boundary during an active chime reloads the counter.
- Alarm trigger:
  - Trigger condition: a tick produces hour==alarm_hour, min==alarm_min, sec==0, with alarm_on=1.
  - On trigger, alarm goes high next cycle and its counter loads ALARM_LEN.
  - alarm falls when the counter reaches 0 on a tick, or on the cycle after alarm_ack=1, or on the cycle after alarm_on=0, whichever comes first.
  - If alarm_ack=1 and a trigger occur in the same cycle, the trigger wins.
  - tweet and alarm are independent and may both be high.
- Reset mid-chime or mid-alarm clears both outputs on the next edge.

Test Plan:
- Rollover (DIV=1): preload 23:59:58, two en pulses.
  - Required: 23:59:59, then 00:00:00.
  - tweet high for 3 ticks, then 0.
  - pm falls from 1 to 0.
- Prescaler (DIV=4): 8 en pulses from reset.
  - Required: sec=8'h02.
  - Cycles without en do not advance the prescaler.
- Adjust: hold adj_minute high 10 cycles at 00:59:30.
  - Required: a single increment to 00:00:30, hour still 00, no tweet.
  - Then an adj_hour rise coincident with a 00:59:59 tick gives hour=01 exactly once.
- 12 h mode: hours 0, 12, 13 with mode_12h=1.
  - Required: hour=12/pm=0, 12/pm=1, 01/pm=1 respectively.
- Alarm load and fire: write 07:30, alarm_on=1, run to 07:30:00.
  - Required: alarm rises the cycle after the tick.
  - alarm_ack at tick 5 drops it the next cycle.
  - Repeat without ack: alarm lasts exactly 30 ticks.
  - Writing alarm_hour_in=24 leaves 07:30 unchanged.
- Reset mid-operation: assert rst while tweet=1 and alarm=1.
  - Required: the next edge gives 00:00:00, tweet=0, alarm=0, and the alarm registers read back as 00:00.
